ob_cn_reissue: RTL and testbench
================================

# ob_cn_reissue

Re-issue stage that sits directly downstream of the conditional-order table. It accepts matured conditional commands over the `mtr_` handshake and buffers them in a small FIFO. It then merges them with the external ingress command stream into one registered command port feeding the order-book controller. Matured commands have priority, and a bounded starvation counter guarantees ingress progress.

## Interface
- `DEPTH`, 4: matured-command FIFO entries; must be ≥2, any integer.
- `STARVE_MAX`, 8: maximum consecutive matured wins while ingress waits; must be ≥1.

- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `mtr_vld_r`  in  1  matured command valid, from conditional table.
- `mtr_r`  in  `ob_pkg::cmd_t`  matured command.
- `mtr_accept`  out  1  matured command taken this cycle.
- `in_vld`  in  1  ingress command valid.
- `in_cmd`  in  `ob_pkg::cmd_t`  ingress command.
- `in_accept`  out  1  ingress command taken this cycle.
- `out_vld_r`  out  1  registered command valid to controller.
- `out_cmd_r`  out  `ob_pkg::cmd_t`  registered command.
- `out_is_cn_r`  out  1  output command originated from the conditional table.
- `out_accept`  in  1  controller consumes the output.
- `occ_r`  out  `$clog2(DEPTH+1)`  FIFO occupancy.
- `full_r`  out  1  `occ_r == DEPTH`.

## Operation
**Push**
- `mtr_accept = ~full_r & ~rst`.
- A push occurs when `mtr_vld_r & mtr_accept`. The command is written at the write pointer.
- Pointers wrap from DEPTH-1 to 0.

**Output load**
- `load = ~out_vld_r | out_accept`.

**Candidate selection**
- The CN candidate is the FIFO head when `occ_r != 0`. Otherwise it is the bypass candidate (see Configuration), if enabled.
- `sel_in` is true when `in_vld` and any of the following holds:
  - no CN candidate exists;
  - `starve_cnt == STARVE_MAX`.
- Otherwise `sel_cn` is true when a CN candidate exists.

**Load and consume**
- On `load & sel_cn`: pop the FIFO (or consume the bypass), then load `out_cmd_r` and set `out_is_cn_r=1`.
- On `load & sel_in`:
  - `in_accept=1`;
  - load `in_cmd` and set `out_is_cn_r=0`.
- `in_accept` is 0 in all other cycles.

**Output valid update**
- `load` with a selection sets `out_vld_r`.
- `out_accept` without a new load clears `out_vld_r`.
- `out_cmd_r` and `out_is_cn_r` update only on a load.

**Starvation counter**, width `$clog2(STARVE_MAX+1)`
- Increments on a `sel_cn` load while `in_vld` is high.
- Clears on a `sel_in` load, or on any cycle with `in_vld` low.
- Saturates at STARVE_MAX.

**Occupancy**
- `occ_r` increments on push only and decrements on pop only.
- Simultaneous push and pop leaves `occ_r` unchanged.
- A push and a pop never occur while `occ_r` is both full and empty; push is blocked when full.
- `full_r` is registered from the next-state occupancy.

**Ordering**
- Matured commands leave in arrival order. Ingress order is preserved.

## Timing
- Reset values:
  - `out_vld_r=0`, `out_is_cn_r=0`, `out_cmd_r='0`;
  - `occ_r=0`, `full_r=0`, starvation counter 0;
  - `mtr_accept=0` and `in_accept=0` while `rst`.
- Reset mid-operation discards FIFO contents and any held output. This takes effect at the reset edge.
- Ingress latency: accepted in cycle N, then `out_vld_r` in N+1.
- Matured latency without bypass:
  - push in N, FIFO head in N+1;
  - earliest `out_vld_r` in N+2.
- Full FIFO: `mtr_accept=0` until a pop is registered. It reasserts the cycle after the pop.
- Output stalled (`out_vld_r & ~out_accept`): no pops and `in_accept=0`. Pushes continue until full.

## Configuration
- `OB_CN_REISSUE_BYPASS_EN` defined: when `occ_r==0` and a push is occurring, the incoming `mtr_r` is the CN candidate. If it is selected, it loads `out_cmd_r` directly and is not written to the FIFO, so the matured latency is 1 cycle.
- If the bypass candidate is not selected, the push proceeds normally.
- Undefined: no bypass; every matured command passes through the FIFO, with a minimum 2-cycle latency.

## Test plan
- **Ingress only**: `in_vld` held for 3 commands, `out_accept=1` → `out_vld_r` from cycle 1; commands appear in order with `out_is_cn_r=0` and `in_accept=1` every cycle.
- **Fill FIFO**: `DEPTH=4`, `out_accept=0`, 5 matured commands offered:
  - `mtr_accept` goes low after the 4th push, with `full_r=1` and `occ_r=4`;
  - the 5th is held until one `out_accept` pulse, then accepted the next cycle.
- **Starvation**: FIFO continuously refilled, `in_vld=1`, `STARVE_MAX=8`, `out_accept=1` → 8 CN outputs, then 1 ingress output, with the pattern repeating.
- **Simultaneous push/pop at `occ_r=2`** → `occ_r` stays 2; output order equals push order.
- **Reset with `occ_r=3` and `out_vld_r=1`** → next cycle `occ_r=0`, `out_vld_r=0`, `full_r=0`; a subsequent push emerges with the correct latency.
- **Bypass**, with and without `OB_CN_REISSUE_BYPASS_EN`: single matured command into an empty block with `in_vld=0` → `out_vld_r` at N+1 with bypass, N+2 without, `out_is_cn_r=1`.

Source files
------------

// File: rtl/ob_cn_reissue.sv
// Re-issue stage: buffers matured conditional commands and merges them with ingress onto one registered port.
// Optional same-cycle bypass of an empty FIFO is enabled by defining OB_CN_REISSUE_BYPASS_EN.
package ob_pkg;
    typedef struct packed {
        logic [1:0]  op;
        logic [13:0] qty;
        logic [15:0] id;
    } cmd_t;
endpackage

module ob_cn_reissue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mtr_vld_r,
    input  ob_pkg::cmd_t                 mtr_r,
    output logic                         mtr_accept,
    input  logic                         in_vld,
    input  ob_pkg::cmd_t                 in_cmd,
    output logic                         in_accept,
    output logic                         out_vld_r,
    output ob_pkg::cmd_t                 out_cmd_r,
    output logic                         out_is_cn_r,
    input  logic                         out_accept,
    output logic [$clog2(DEPTH+1)-1:0]   occ_r,
    output logic                         full_r
);
    localparam int unsigned OW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    ob_pkg::cmd_t   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]  occ_q, occ_d;
    logic           full_q;
    logic [SW-1:0]  starve_q, starve_d;
    logic           out_vld_q, out_vld_d;
    ob_pkg::cmd_t   out_cmd_q, out_cmd_d;
    logic           out_is_cn_q, out_is_cn_d;

    logic           push, wr, pop, load, fifo_ne, byp_avail, cn_avail;
    logic           sel_in, sel_cn, take_cn;
    ob_pkg::cmd_t   cn_cmd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mtr_accept = ~full_q & ~rst;
        push       = mtr_vld_r & mtr_accept;
        load       = ~out_vld_q | out_accept;
        fifo_ne    = (occ_q != '0);
`ifdef OB_CN_REISSUE_BYPASS_EN
        byp_avail  = ~fifo_ne & push;
`else
        byp_avail  = 1'b0;
`endif
        cn_avail   = fifo_ne | byp_avail;
        sel_in     = in_vld & (~cn_avail | (starve_q == SW'(STARVE_MAX)));
        sel_cn     = ~sel_in & cn_avail;
        take_cn    = load & sel_cn;
        pop        = take_cn & fifo_ne;
        // a bypassed command is consumed straight from mtr_r and never written
        wr         = push & ~(take_cn & ~fifo_ne);
        in_accept  = load & sel_in & ~rst;
        cn_cmd     = fifo_ne ? mem_q[rd_ptr_q] : mtr_r;

        wr_ptr_d = wr  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        occ_d = occ_q;
        if (wr && !pop) begin
            occ_d = occ_q + OW'(1);
        end else if (!wr && pop) begin
            occ_d = occ_q - OW'(1);
        end

        starve_d = starve_q;
        if (!in_vld || (load && sel_in)) begin
            starve_d = '0;
        end else if (take_cn && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end

        out_vld_d   = out_vld_q;
        out_cmd_d   = out_cmd_q;
        out_is_cn_d = out_is_cn_q;
        if (take_cn) begin
            out_vld_d   = 1'b1;
            out_cmd_d   = cn_cmd;
            out_is_cn_d = 1'b1;
        end else if (load && sel_in) begin
            out_vld_d   = 1'b1;
            out_cmd_d   = in_cmd;
            out_is_cn_d = 1'b0;
        end else if (load) begin
            out_vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            full_q      <= 1'b0;
            starve_q    <= '0;
            out_vld_q   <= 1'b0;
            out_cmd_q   <= '0;
            out_is_cn_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            full_q      <= (occ_d == OW'(DEPTH));
            starve_q    <= starve_d;
            out_vld_q   <= out_vld_d;
            out_cmd_q   <= out_cmd_d;
            out_is_cn_q <= out_is_cn_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= mtr_r;
        end
    end

    assign out_vld_r   = out_vld_q;
    assign out_cmd_r   = out_cmd_q;
    assign out_is_cn_r = out_is_cn_q;
    assign occ_r       = occ_q;
    assign full_r      = full_q;
endmodule

// File: tb/tb_ob_cn_reissue.sv
// Directed bench for ob_cn_reissue: queue-based reference model checked every cycle plus literal checkpoints.
module tb_ob_cn_reissue;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned STARVE_MAX = 8;
`ifdef OB_CN_REISSUE_BYPASS_EN
    localparam int EXP_LAT = 1;
    localparam bit BYP     = 1'b1;
`else
    localparam int EXP_LAT = 2;
    localparam bit BYP     = 1'b0;
`endif

    logic          clk, rst;
    logic          mtr_vld_r, mtr_accept, in_vld, in_accept;
    logic          out_vld_r, out_is_cn_r, out_accept, full_r;
    ob_pkg::cmd_t  mtr_r, in_cmd, out_cmd_r;
    logic [2:0]    occ_r;

    int tests = 0;
    int fails = 0;

    ob_cn_reissue #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .mtr_vld_r(mtr_vld_r), .mtr_r(mtr_r), .mtr_accept(mtr_accept),
        .in_vld(in_vld), .in_cmd(in_cmd), .in_accept(in_accept),
        .out_vld_r(out_vld_r), .out_cmd_r(out_cmd_r), .out_is_cn_r(out_is_cn_r),
        .out_accept(out_accept), .occ_r(occ_r), .full_r(full_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ob_pkg::cmd_t mk(input logic [15:0] id);
        mk = '{op: 2'd1, qty: id[13:0] ^ 14'h2A5, id: id};
    endfunction

    // Reference model: FIFO as a queue, output register as plain variables.
    ob_pkg::cmd_t mq[$];
    logic         m_vld = 1'b0;
    ob_pkg::cmd_t m_cmd = '0;
    logic         m_cn  = 1'b0;
    int           m_starve = 0;
    bit           armed = 1'b0;

    always @(posedge clk) if (rst) armed = 1'b1;

    always @(negedge clk) begin
        if (armed) begin
            bit e_macc, push, load, have_cn, s_in, s_cn;
            e_macc  = !rst && (mq.size() < DEPTH);
            push    = mtr_vld_r && e_macc;
            load    = !m_vld || out_accept;
            have_cn = (mq.size() != 0) || (BYP && push);
            s_in    = in_vld && (!have_cn || m_starve == STARVE_MAX);
            s_cn    = !s_in && have_cn;

            chk("mtr_accept", mtr_accept, e_macc);
            chk("in_accept", in_accept, !rst && load && s_in);
            chk("out_vld_r", out_vld_r, m_vld);
            chk("out_cmd_r", out_cmd_r, m_cmd);
            chk("out_is_cn_r", out_is_cn_r, m_cn);
            chk("occ_r", occ_r, mq.size());
            chk("full_r", full_r, mq.size() == DEPTH);

            if (rst) begin
                mq.delete();
                m_vld = 1'b0; m_cmd = '0; m_cn = 1'b0; m_starve = 0;
            end else begin
                if (push) mq.push_back(mtr_r);
                if (load && s_cn) begin
                    m_cmd = mq.pop_front(); m_cn = 1'b1; m_vld = 1'b1;
                end else if (load && s_in) begin
                    m_cmd = in_cmd; m_cn = 1'b0; m_vld = 1'b1;
                end else if (load) begin
                    m_vld = 1'b0;
                end
                if (!in_vld || (load && s_in)) m_starve = 0;
                else if (load && s_cn && m_starve < STARVE_MAX) m_starve++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int last_zero, zeros;
        bit seq[$];

        rst = 1'b1; mtr_vld_r = 1'b0; mtr_r = '0; in_vld = 1'b0; in_cmd = '0; out_accept = 1'b0;
        tick; tick;
        chk("rst_out_vld", out_vld_r, 0);
        chk("rst_occ", occ_r, 0);
        chk("rst_full", full_r, 0);
        chk("rst_mtr_accept", mtr_accept, 0);
        chk("rst_out_cmd", out_cmd_r, 0);
        rst = 1'b0;

        // ingress only
        out_accept = 1'b1; in_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_cmd = mk(16'h100 + 16'(i));
            #1 chk("ing_accept", in_accept, 1);
            tick;
            chk("ing_vld", out_vld_r, 1);
            chk("ing_id", out_cmd_r.id, 16'h100 + 16'(i));
            chk("ing_is_cn", out_is_cn_r, 0);
        end
        in_vld = 1'b0;
        tick;
        chk("ing_drained", out_vld_r, 0);

        // fill FIFO behind a stalled output
        out_accept = 1'b0; in_vld = 1'b1; in_cmd = mk(16'h1FF);
        tick;
        in_vld = 1'b0;
        mtr_vld_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mtr_r = mk(16'h200 + 16'(i));
            tick;
        end
        mtr_r = mk(16'h204);
        #1;
        chk("fill_macc_low", mtr_accept, 0);
        chk("fill_occ", occ_r, 4);
        chk("fill_full", full_r, 1);
        tick; tick;
        chk("fill_held_occ", occ_r, 4);
        out_accept = 1'b1;
        tick;
        out_accept = 1'b0;
        chk("fill_pop_id", out_cmd_r.id, 16'h200);
        chk("fill_pop_cn", out_is_cn_r, 1);
        chk("fill_macc_back", mtr_accept, 1);
        tick;
        mtr_vld_r = 1'b0;
        chk("fill_refill_occ", occ_r, 4);

        // drain to occ 2, then push and pop together
        out_accept = 1'b1;
        tick; tick;
        chk("pp_pre_occ", occ_r, 2);
        mtr_vld_r = 1'b1; mtr_r = mk(16'h205);
        tick;
        mtr_vld_r = 1'b0;
        chk("pp_occ", occ_r, 2);
        chk("pp_id", out_cmd_r.id, 16'h203);
        tick;
        chk("order_204", out_cmd_r.id, 16'h204);
        tick;
        chk("order_205", out_cmd_r.id, 16'h205);
        tick;
        chk("order_empty", out_vld_r, 0);

        // reset while holding data
        out_accept = 1'b0; in_vld = 1'b1; in_cmd = mk(16'h300);
        tick;
        in_vld = 1'b0; mtr_vld_r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mtr_r = mk(16'h310 + 16'(i));
            tick;
        end
        mtr_vld_r = 1'b0;
        chk("mid_occ", occ_r, 3);
        chk("mid_vld", out_vld_r, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_occ", occ_r, 0);
        chk("mid_rst_vld", out_vld_r, 0);
        chk("mid_rst_full", full_r, 0);

        // matured latency into an empty block
        out_accept = 1'b1; mtr_vld_r = 1'b1; mtr_r = mk(16'h400);
        tick;
        mtr_vld_r = 1'b0;
        lat = 1;
        while (!out_vld_r && lat < 6) begin
            tick;
            lat++;
        end
        chk("cn_latency", lat, EXP_LAT);
        chk("cn_lat_id", out_cmd_r.id, 16'h400);
        chk("cn_lat_is_cn", out_is_cn_r, 1);
        tick; tick;

        // starvation: matured always available, ingress always waiting
        in_vld = 1'b1; mtr_vld_r = 1'b1; out_accept = 1'b1;
        for (int k = 0; k < 45; k++) begin
            mtr_r  = mk(16'h500 + 16'(k));
            in_cmd = mk(16'h600 + 16'(k));
            tick;
            if (out_vld_r) seq.push_back(out_is_cn_r);
        end
        in_vld = 1'b0; mtr_vld_r = 1'b0;
        last_zero = -1; zeros = 0;
        for (int i = 0; i < seq.size(); i++) begin
            if (!seq[i]) begin
                if (last_zero >= 0) chk("starve_run", i - last_zero - 1, STARVE_MAX);
                last_zero = i;
                zeros++;
            end
        end
        chk("starve_ingress_wins", zeros >= 3, 1);
        repeat (8) tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
